tx_framer: RTL

Transmit-side framer that builds the serial PLCP stream consumed by the receiver controller.
- Emits, in order: a 12-bit all-ones preamble, the 24-bit SIGNAL field, 16 scrambled SERVICE bits, 8*LENGTH scrambled payload bits, then an inter-frame gap of zeros.
- Payload bytes arrive over a ready/valid byte interface and are serialized MSB-first.
- Scrambling uses an embedded x^7+x^4+1 LFSR. The receiver's descrambler can seed itself from the SERVICE bits.

---
 rtl/tx_rx_defs.sv | 45 ++++
 rtl/scrambler_lfsr.sv | 32 +++
 rtl/tx_framer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_rx_defs.sv
// Definitions shared by the PLCP transmit framer and the receive path:
// state encoding, field sizes, SIGNAL layout and scrambler constants.
package tx_rx_defs;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_SIGNAL  = 3'd2;
  localparam logic [2:0] ST_SERVICE = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  localparam int HEADER_LEN  = 12;
  localparam int SIGNAL_LEN  = 24;
  localparam int SERVICE_LEN = 16;

  localparam int SIG_RATE_MSB = 23;
  localparam int SIG_RATE_LSB = 20;
  localparam int SIG_RSVD     = 19;
  localparam int SIG_LEN_MSB  = 18;
  localparam int SIG_LEN_LSB  = 7;
  localparam int SIG_PARITY   = 6;

  localparam logic [11:0] DEFAULT_HEADER  = 12'hFFF;
  localparam logic [6:0]  DEFAULT_SEED    = 7'b1011101;
  localparam int          DEFAULT_IFS_GAP = 12;

  // x^7 + x^4 + 1 taps on a 7-bit state shifting toward the MSB
  localparam int TAP_HI = 6;
  localparam int TAP_LO = 3;

  function automatic logic even_parity(input logic [16:0] bits);
    return ^bits;
  endfunction

  function automatic logic [23:0] build_signal(input logic [3:0] rate, input logic [11:0] len);
    logic [23:0] sig;
    sig = 24'd0;
    sig[SIG_RATE_MSB:SIG_RATE_LSB] = rate;
    sig[SIG_RSVD] = 1'b0;
    sig[SIG_LEN_MSB:SIG_LEN_LSB] = len;
    sig[SIG_PARITY] = even_parity({rate, 1'b0, len});
    return sig;
  endfunction

endpackage

// File: rtl/scrambler_lfsr.sv
// 7-bit x^7+x^4+1 additive scrambler state; shared by framer and descrambler.
module scrambler_lfsr
  import tx_rx_defs::*;
#(
  parameter logic [6:0] RESET_VALUE = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       enable,
  output logic       fb
);

  logic [6:0] state_r;

  assign fb = state_r[TAP_HI] ^ state_r[TAP_LO];

  // Load wins over shift so a new frame always starts from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RESET_VALUE;
    end else if (load) begin
      state_r <= seed;
    end else if (enable) begin
      state_r <= {state_r[5:0], fb};
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/tx_framer.sv
// PLCP transmit framer: preamble, SIGNAL, scrambled SERVICE and payload,
// then a zero inter-frame gap, all on a registered serial output.
module tx_framer
  import tx_rx_defs::*;
#(
  parameter logic [11:0] HEADER  = DEFAULT_HEADER,
  parameter logic [6:0]  SEED    = DEFAULT_SEED,
  parameter int          IFS_GAP = DEFAULT_IFS_GAP
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [3:0]  iRate,
  input  logic [11:0] iLength,
  input  logic [7:0]  iByte,
  input  logic        iByteValid,
  output logic        oByteReady,
  output logic        oData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oStartErr,
  output logic        oUnderrun
);

  logic [2:0]  state_r;
  logic [15:0] cnt_r;
  logic        data_r, busy_r, done_r, start_err_r, underrun_r, ready_r;
  logic [3:0]  rate_r;
  logic [11:0] len_r;
  logic [7:0]  hold_r, shift_r;
  logic        hold_valid_r;
  logic [11:0] accepted_r;

  logic [2:0]  next_state_s;
  logic [15:0] next_cnt_s;
  logic        next_data_s, accept_s, reject_s, boundary_s, transfer_s;
  logic        next_hold_valid_s, next_ready_s, lfsr_en_s, fb_s;
  logic [11:0] next_accepted_s;
  logic [7:0]  byte_s;
  logic [23:0] signal_s;
  logic [15:0] data_cnt_load_s;

  assign signal_s        = build_signal(rate_r, len_r);
  assign data_cnt_load_s = {1'b0, len_r, 3'b000} - 16'd1;
  assign transfer_s      = iByteValid && ready_r;
  assign lfsr_en_s       = (next_state_s == ST_SERVICE) || (next_state_s == ST_DATA);

  scrambler_lfsr #(.RESET_VALUE(SEED)) u_lfsr (
    .clk    (iClk),
    .rst    (iRst),
    .load   (accept_s),
    .seed   (SEED),
    .enable (lfsr_en_s),
    .fb     (fb_s)
  );

  // Field sequencing: the counter holds the index of the bit placed on oData
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iStart && (iLength != 12'd0)) begin
          accept_s     = 1'b1;
          next_state_s = ST_HEADER;
          next_cnt_s   = 16'(HEADER_LEN - 1);
        end else if (iStart) begin
          reject_s = 1'b1;
        end else begin
          reject_s = 1'b0;
        end
      end
      ST_HEADER, ST_SIGNAL, ST_SERVICE, ST_DATA, ST_GAP: begin
        if (cnt_r != 16'd0) begin
          next_cnt_s = cnt_r - 16'd1;
        end else begin
          case (state_r)
            ST_HEADER: begin
              next_state_s = ST_SIGNAL;
              next_cnt_s   = 16'(SIGNAL_LEN - 1);
            end
            ST_SIGNAL: begin
              next_state_s = ST_SERVICE;
              next_cnt_s   = 16'(SERVICE_LEN - 1);
            end
            ST_SERVICE: begin
              next_state_s = ST_DATA;
              next_cnt_s   = data_cnt_load_s;
            end
            ST_DATA: begin
              next_state_s = ST_GAP;
              next_cnt_s   = 16'(IFS_GAP - 1);
            end
            default: begin
              next_state_s = ST_IDLE;
              next_cnt_s   = 16'd0;
            end
          endcase
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_cnt_s   = 16'd0;
      end
    endcase
  end

  // Next serial bit; a byte boundary is the MSB of each payload byte
  always_comb begin
    boundary_s  = 1'b0;
    byte_s      = hold_valid_r ? hold_r : 8'h00;
    next_data_s = 1'b0;
    case (next_state_s)
      ST_HEADER:  next_data_s = HEADER[next_cnt_s[3:0]];
      ST_SIGNAL:  next_data_s = signal_s[next_cnt_s[4:0]];
      ST_SERVICE: next_data_s = fb_s;
      ST_DATA: begin
        if (next_cnt_s[2:0] == 3'd7) begin
          boundary_s  = 1'b1;
          next_data_s = byte_s[7] ^ fb_s;
        end else begin
          next_data_s = shift_r[7] ^ fb_s;
        end
      end
      default: next_data_s = 1'b0;
    endcase
  end

  // Byte-path bookkeeping; a transfer needs an empty holding register
  always_comb begin
    if (accept_s) begin
      next_hold_valid_s = 1'b0;
      next_accepted_s   = 12'd0;
    end else if (transfer_s) begin
      next_hold_valid_s = 1'b1;
      next_accepted_s   = accepted_r + 12'd1;
    end else begin
      next_hold_valid_s = boundary_s ? 1'b0 : hold_valid_r;
      next_accepted_s   = accepted_r;
    end
    next_ready_s = lfsr_en_s && !next_hold_valid_s && (next_accepted_s < len_r);
  end

  // Framer state and registered outputs
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      data_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      start_err_r  <= 1'b0;
      underrun_r   <= 1'b0;
      ready_r      <= 1'b0;
      rate_r       <= 4'd0;
      len_r        <= 12'd0;
      hold_r       <= 8'h00;
      hold_valid_r <= 1'b0;
      shift_r      <= 8'h00;
      accepted_r   <= 12'd0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= next_cnt_s;
      data_r       <= next_data_s;
      busy_r       <= (next_state_s != ST_IDLE);
      done_r       <= (next_state_s == ST_GAP) && (next_cnt_s == 16'd0);
      start_err_r  <= reject_s;
      ready_r      <= next_ready_s;
      hold_valid_r <= next_hold_valid_s;
      accepted_r   <= next_accepted_s;
      if (accept_s) begin
        rate_r     <= iRate;
        len_r      <= iLength;
        underrun_r <= 1'b0;
      end else begin
        rate_r     <= rate_r;
        len_r      <= len_r;
        underrun_r <= underrun_r | (boundary_s && !hold_valid_r);
      end
      hold_r <= transfer_s ? iByte : hold_r;
      if (boundary_s) begin
        shift_r <= {byte_s[6:0], 1'b0};
      end else if (next_state_s == ST_DATA) begin
        shift_r <= {shift_r[6:0], 1'b0};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  assign oData      = data_r;
  assign oBusy      = busy_r;
  assign oDone      = done_r;
  assign oStartErr  = start_err_r;
  assign oUnderrun  = underrun_r;
  assign oByteReady = ready_r;

endmodule
